// File: rtl/fifo_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_arb_pkg
// Description : Shared types and helpers for the FIFO write-port arbiters.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  // Index width for n items; a single bit is kept even when n <= 2.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int wrap_inc(input int i, input int n);
    return (i >= n - 1) ? 0 : i + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_wr_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Rotating-priority encoder; first set request at or after ptr.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic          o_any
);

  always_comb begin
    int w_idx;
    w_idx   = 0;
    o_grant = '0;
    o_any   = 1'b0;
    for (int k = 0; k < N; k++) begin
      w_idx = int'(i_ptr) + k;
      if (w_idx >= N) w_idx = w_idx - N;
      if (!o_any && i_req[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        o_any          = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fifo_wr_arbiter
// Description : Round-robin packet-locking arbiter for a FIFO write port.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int WIDTH        = 8,
  parameter int LOCK_TIMEOUT = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [WIDTH-1:0]            req_data [NUM_REQ],
  input  logic [NUM_REQ-1:0]          req_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WIDTH-1:0]            out_data,
  output logic                        out_last,
  output logic [idx_w(NUM_REQ)-1:0]   out_src,
  output logic                        locked,
  output logic                        err_timeout
);

  localparam int IW = idx_w(NUM_REQ);
  localparam int CW = idx_w(LOCK_TIMEOUT + 1);
  localparam logic [0:0] S_IDLE   = ARB_IDLE;
  localparam logic [0:0] S_LOCKED = ARB_LOCKED;
  localparam logic [CW-1:0] c_TIMEOUT_LAST = CW'((LOCK_TIMEOUT == 0) ? 0 : LOCK_TIMEOUT - 1);

  logic [0:0]         r_state;
  logic [IW-1:0]      r_rr_ptr;
  logic [IW-1:0]      r_owner;
  logic [CW-1:0]      r_idle_cnt;
  logic               r_out_valid;
  logic [WIDTH-1:0]   r_out_data;
  logic               r_out_last;
  logic [IW-1:0]      r_out_src;
  logic               r_err;

  logic [NUM_REQ-1:0] w_pick_grant;
  logic               w_pick_any;
  logic [NUM_REQ-1:0] w_grant;
  logic [IW-1:0]      w_sel;
  logic               w_load;
  logic               w_accept;
  logic               w_owner_idle;
  logic               w_timeout;

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_rr_pick (
    .i_req   (req_valid),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_pick_grant),
    .o_any   (w_pick_any)
  );

  // While locked only the owner may be granted, regardless of rotation.
  always_comb begin
    w_grant = '0;
    if (r_state == S_LOCKED) w_grant[r_owner] = req_valid[r_owner];
    else                     w_grant = w_pick_grant;
  end

  always_comb begin
    w_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) w_sel = IW'(i);
    end
  end

  assign w_load       = ~r_out_valid | out_ready;
  assign w_accept     = w_load & ((r_state == S_LOCKED) ? req_valid[r_owner] : w_pick_any);
  assign w_owner_idle = (r_state == S_LOCKED) & ~req_valid[r_owner];
  assign w_timeout    = (LOCK_TIMEOUT != 0) && w_owner_idle && (r_idle_cnt == c_TIMEOUT_LAST);
  assign req_ready    = {NUM_REQ{w_load & ~reset}} & w_grant;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= '0;
      r_owner     <= '0;
      r_idle_cnt  <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_out_src   <= '0;
      r_err       <= 1'b0;
    end else begin
      r_err <= w_timeout;
      if (w_load) begin
        r_out_valid <= w_accept;
        if (w_accept) begin
          r_out_data <= req_data[w_sel];
          r_out_last <= req_last[w_sel];
          r_out_src  <= w_sel;
        end
      end
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (req_last[w_sel]) begin
              r_rr_ptr <= IW'(wrap_inc(int'(w_sel), NUM_REQ));
            end else begin
              r_state    <= S_LOCKED;
              r_owner    <= w_sel;
              r_idle_cnt <= '0;
            end
          end
        end
        default: begin
          if (w_accept) begin
            r_idle_cnt <= '0;
            if (req_last[r_owner]) begin
              r_state  <= S_IDLE;
              r_rr_ptr <= IW'(wrap_inc(int'(r_owner), NUM_REQ));
            end
          end else if (w_timeout) begin
            r_state    <= S_IDLE;
            r_rr_ptr   <= IW'(wrap_inc(int'(r_owner), NUM_REQ));
            r_idle_cnt <= '0;
          end else if (w_owner_idle) begin
            if (r_idle_cnt != '1) r_idle_cnt <= r_idle_cnt + CW'(1);
          end else begin
            // Owner valid but FIFO backpressured: not a stall.
            r_idle_cnt <= '0;
          end
        end
      endcase
    end
  end

  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign out_last    = r_out_last;
  assign out_src     = r_out_src;
  assign locked      = (r_state == S_LOCKED);
  assign err_timeout = r_err;

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_wr_arbiter
// Description : Directed and random checks of fifo_wr_arbiter against a model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_ready;
  logic [W-1:0]  req_data [N];
  logic [N-1:0]  req_last;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          out_last;
  logic [1:0]    out_src;
  logic          locked;
  logic          err_timeout;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: packet owner, rotation pointer and output beat.
  bit           m_ov, m_ol, m_locked, m_err;
  logic [W-1:0] m_od;
  int           m_src, m_owner, m_ptr, m_idle;

  fifo_wr_arbiter #(
    .NUM_REQ      (N),
    .WIDTH        (W),
    .LOCK_TIMEOUT (TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_data    (req_data),
    .req_last    (req_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last),
    .out_src     (out_src),
    .locked      (locked),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic [N-1:0] v, input logic [N-1:0] l);
    req_valid = v;
    req_last  = l;
    for (int i = 0; i < N; i++) req_data[i] = W'($urandom);
  endtask

  // Called at a falling edge with inputs already applied; returns at the next falling edge.
  task automatic step();
    int           g;
    bit           load, to;
    logic [N-1:0] exp_rdy;
    #1;
    load = !m_ov || out_ready;
    g    = -1;
    if (m_locked) begin
      if (req_valid[m_owner]) g = m_owner;
    end else begin
      for (int k = 0; k < N; k++)
        if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    end
    exp_rdy = (!reset && load && g >= 0) ? (N'(1) << g) : '0;
    check("req_ready", req_ready, exp_rdy);
    to = m_locked && !req_valid[m_owner] && (m_idle + 1 == TO);
    if (reset) begin
      m_ov = 0; m_ol = 0; m_od = '0; m_src = 0; m_locked = 0; m_err = 0;
      m_owner = 0; m_ptr = 0; m_idle = 0;
    end else begin
      m_err = to;
      if (load) begin
        m_ov = (g >= 0);
        if (g >= 0) begin
          m_od = req_data[g]; m_ol = req_last[g]; m_src = g;
        end
      end
      if (load && g >= 0) begin
        if (req_last[g]) begin
          m_locked = 0; m_ptr = (g + 1) % N;
        end else begin
          m_locked = 1; m_owner = g; m_idle = 0;
        end
      end else if (m_locked) begin
        if (req_valid[m_owner]) m_idle = 0;
        else if (to) begin
          m_locked = 0; m_ptr = (m_owner + 1) % N; m_idle = 0;
        end else m_idle++;
      end
    end
    @(posedge clk);
    #1;
    check("out_valid", out_valid, m_ov);
    check("out_data", out_data, m_od);
    check("out_last", out_last, m_ol);
    check("out_src", out_src, m_src);
    check("locked", locked, m_locked);
    check("err_timeout", err_timeout, m_err);
    @(negedge clk);
  endtask

  initial begin
    reset     = 1'b1;
    out_ready = 1'b1;
    set_in('0, '0);
    m_ov = 0; m_ol = 0; m_od = '0; m_src = 0; m_locked = 0; m_err = 0;
    m_owner = 0; m_ptr = 0; m_idle = 0;
    @(negedge clk);
    step();
    step();
    reset = 1'b0;

    // Single-beat packets from everyone: strict rotation.
    for (int c = 0; c < 8; c++) begin
      set_in(4'hF, 4'hF);
      step();
      check("t1_rotation", out_src, c % 4);
    end

    // Three-beat packet from producer 2 stays contiguous.
    set_in(4'b0100, 4'b0000); step();
    check("t2_src0", out_src, 2); check("t2_lock0", locked, 1);
    set_in(4'hF, 4'b1011); step();
    check("t2_src1", out_src, 2); check("t2_lock1", locked, 1);
    set_in(4'hF, 4'hF); step();
    check("t2_src2", out_src, 2); check("t2_lock2", locked, 0);
    set_in(4'hF, 4'hF); step();
    check("t2_src3", out_src, 3);

    // Backpressure holds a pending 0xA5 beat.
    set_in(4'b0001, 4'b0001); req_data[0] = 8'hA5; step();
    check("t3_data", out_data, 8'hA5);
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      set_in(4'hF, 4'hF); step();
      check("t3_hold", out_data, 8'hA5);
      check("t3_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    set_in(4'hF, 4'hF); step();
    check("t3_next_src", out_src, 1);

    // Owner stalls mid-packet: watchdog releases after TO idle cycles.
    set_in('0, '0); step();
    set_in(4'b0010, 4'b0000); step();
    for (int c = 0; c < 4; c++) begin
      set_in(4'b0100, 4'b0100); step();
      check("t4_err", err_timeout, (c == 3));
    end
    set_in(4'b0100, 4'b0100); step();
    check("t4_src", out_src, 2);
    check("t4_err_clear", err_timeout, 0);

    // Backpressure with a valid owner is never idle.
    set_in(4'b1000, 4'b0000); step();
    out_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      set_in(4'b1000, 4'b0000); step();
      check("t5_locked", locked, 1);
      check("t5_no_err", err_timeout, 0);
    end
    out_ready = 1'b1;
    set_in(4'b1000, 4'b1000); step();

    // Reset in the middle of a packet.
    set_in(4'b0001, 4'b0000); step();
    reset = 1'b1; set_in(4'hF, 4'hF); step();
    check("t6_valid", out_valid, 0);
    check("t6_locked", locked, 0);
    reset = 1'b0; set_in(4'hF, 4'hF); step();
    check("t6_src", out_src, 0);

    // Random traffic with backpressure and stalls.
    for (int c = 0; c < 400; c++) begin
      logic [N-1:0] v, l;
      for (int i = 0; i < N; i++) begin
        v[i] = ($urandom_range(0, 9) < 6);
        l[i] = ($urandom_range(0, 2) == 0);
      end
      set_in(v, l);
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin, packet-locking arbiter that shares the single write port of the team's synchronous FIFOs (e.g. the 1-write/4-read FIFO) among NUM_REQ producers.
- Grants one producer per cycle and holds the grant until that producer's packet ends, so multi-beat packets enter the FIFO contiguously.
- Registered output stage sits directly in front of the FIFO write interface (out_ready connects to FIFO ready_in).
- Lock watchdog releases a producer that stalls mid-packet.

Parameters:
- NUM_REQ, 4, number of producers (2..8).
- WIDTH, 8, data width per beat.
- LOCK_TIMEOUT, 16, consecutive idle cycles of the lock owner before forced release; 0 disables the watchdog.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-producer beat valid
- req_ready  out  NUM_REQ  per-producer beat accepted
- req_data  in  NUM_REQ x WIDTH  per-producer beat data (unpacked array)
- req_last  in  NUM_REQ  beat is final beat of packet
- out_valid  out  1  FIFO-side beat valid
- out_ready  in  1  FIFO-side ready (FIFO ready_in)
- out_data  out  WIDTH  granted beat data
- out_last  out  1  granted beat is last
- out_src  out  clog2(NUM_REQ)  index of producer that supplied out_data
- locked  out  1  a packet is in progress (lock held)
- err_timeout  out  1  one-cycle pulse on watchdog release

Behaviour:
- Reset values:
  - Outputs: out_valid=0, out_data=0, out_last=0, out_src=0, locked=0, err_timeout=0, req_ready=0.
  - Internal: rr_ptr=0, state=IDLE, owner=0, idle_cnt=0.
- Output register load enable: load = ~out_valid | out_ready. The register takes a new beat when load and a grant exists; otherwise it holds. If load is high and no grant exists, out_valid clears to 0.
- Latency: a beat accepted at edge N is presented on out_* in the cycle after edge N. Full throughput is one beat per cycle while out_ready=1.
- req_ready[i] = load & grant[i]. This is combinational: it depends on out_ready and req_valid, and no req_valid depends on req_ready. grant is one-hot or zero.
- States: IDLE, LOCKED.
- IDLE:
  - grant goes to the first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - On accept of a beat with req_last=1: stay IDLE, rr_ptr <= i+1 mod NUM_REQ.
  - On accept with req_last=0: go to LOCKED, owner <= i, idle_cnt <= 0.
- LOCKED:
  - Only owner is eligible; other requesters see req_ready=0 regardless of priority.
  - On accept with req_last=1: go to IDLE, rr_ptr <= owner+1 mod NUM_REQ.
  - On accept with req_last=0: stay LOCKED, idle_cnt <= 0.
  - If req_valid[owner]=0: idle_cnt increments, saturating.
  - If req_valid[owner]=1 but load=0 (FIFO backpressure): idle_cnt <= 0. Backpressure never counts as idle.
  - Watchdog: when LOCK_TIMEOUT!=0 and idle_cnt reaches LOCK_TIMEOUT-1 while still idle, next state is IDLE, rr_ptr <= owner+1, and err_timeout pulses for one cycle. The partial packet is not repaired downstream.
- locked = (state==LOCKED).
- rr_ptr and owner arithmetic is modulo NUM_REQ. Wrap from NUM_REQ-1 to 0 is explicit, not a power-of-two truncation.
- Fairness: with all producers sending single-beat packets continuously, grants rotate 0,1,2,...,NUM_REQ-1,0. No producer waits more than NUM_REQ-1 packets.
- Simultaneous last-beat accept and new-request arrival in the same cycle: the new arbitration uses the updated rr_ptr on the next cycle only. There are no same-cycle double grants.
- out_valid=1 with out_ready=0: out_data, out_last and out_src are held stable, and no req_ready is asserted.
- Reset mid-packet: the lock is dropped and the output beat is discarded; the FIFO side must be reset concurrently.

Decomposition:
- Shared package fifo_arb_pkg holds:
  - arb_state_e enum {IDLE, LOCKED}
  - localparam function for the index width clog2 of NUM_REQ (minimum 1)
- One natural sub-module: rr_pick. It is a combinational rotate-priority-encoder with inputs req and ptr and outputs one-hot grant and any. It is reusable by other arbiters in the codebase.

Test Plan:
- All 4 valid, single-beat packets, out_ready=1 for 8 cycles -> out_src sequence 0,1,2,3,0,1,2,3. Each out_data equals the supplying producer's data, delayed by 1 cycle.
- Producer 2 sends 3-beat packet (last on beat 3) while producers 0,1,3 are valid -> out_src 2,2,2 contiguous, then 3. locked=1 for exactly the first two accept cycles.
- out_ready held 0 for 5 cycles with beat 0xA5 pending -> out_valid=1, out_data=0xA5 stable, all req_ready=0. After release, next beat follows the next cycle.
- LOCK_TIMEOUT=4: producer 1 sends non-last beat, then drops req_valid -> err_timeout pulses once, 4 cycles after the last accept. Producer 2 is granted on the next cycle.
- Owner valid but out_ready=0 for 10 cycles with LOCK_TIMEOUT=4 -> no err_timeout, lock retained.
- Reset asserted mid-packet -> next cycle out_valid=0, locked=0, rr_ptr=0. Producer 0 wins if all are valid.
